// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD controller slice: state encoding and parameter defaults.
package gcd_pkg;

  localparam int unsigned GCD_WIDTH    = 16;
  localparam int unsigned GCD_MAX_ITER = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CALC   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } gcd_state_e;

endpackage

// File: rtl/gcd_iter_cnt.sv
// Subtraction counter for the GCD controller: clear, saturating increment, limit flag.
module gcd_iter_cnt
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH    = GCD_WIDTH,
  parameter int unsigned MAX_ITER = GCD_MAX_ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  // High when the next increment would make the count equal MAX_ITER.
  assign at_limit = (count == WIDTH'(MAX_ITER - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for a subtractive GCD datapath: loads operands, steers the subtractor,
// and reports completion or an iteration-limit error.
module gcd_controller
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH    = GCD_WIDTH,
  parameter int unsigned MAX_ITER = GCD_MAX_ITER
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  output logic             ldA,
  output logic             ldB,
  output logic             sel1,
  output logic             sel2,
  output logic             sel_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] iter_count
);

  gcd_state_e state_q, state_d;
  logic       cnt_clr, cnt_inc, cnt_at_limit;

  gcd_iter_cnt #(
    .WIDTH   (WIDTH),
    .MAX_ITER(MAX_ITER)
  ) u_iter_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .count   (iter_count),
    .at_limit(cnt_at_limit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ldA     = 1'b0;
    ldB     = 1'b0;
    sel1    = 1'b0;
    sel2    = 1'b0;
    sel_in  = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    busy    = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_A;
          cnt_clr = 1'b1;
        end
      end
      LOAD_A: begin
        ldA     = 1'b1;
        sel_in  = 1'b1;
        state_d = LOAD_B;
      end
      LOAD_B: begin
        ldB     = 1'b1;
        sel_in  = 1'b1;
        state_d = CALC;
      end
      CALC: begin
        // eq wins over gt/lt; with no status bit high the state simply holds.
        if (eq) begin
          state_d = DONE;
        end else if (gt) begin
          ldA     = 1'b1;
          sel1    = 1'b1;
          cnt_inc = 1'b1;
          if (cnt_at_limit) state_d = ERR;
        end else if (lt) begin
          ldB     = 1'b1;
          sel2    = 1'b1;
          cnt_inc = 1'b1;
          if (cnt_at_limit) state_d = ERR;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
